// File: rtl/fifo_wptr_ctrl.sv
// Write-side pointer controller for a dual-clock FIFO (write clock domain).
// Keeps the binary and Gray write pointers, brings the Gray read pointer
// across with a two-flop synchroniser, and derives full, almost_full, the
// fill level and the overflow pulse from the synchronised read pointer.
module fifo_wptr_ctrl #(
  parameter int AW    = 4,
  parameter int AF_TH = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW:0]   rptr_gray,
  output logic [AW-1:0] waddr,
  output logic          wram_we,
  output logic [AW:0]   wptr_gray,
  output logic          full,
  output logic          almost_full,
  output logic [AW:0]   wlevel,
  output logic          overflow
);

  localparam logic [AW:0] AF_TH_W = (AW+1)'(AF_TH);

  logic [AW:0] wbin_q, wbin_d;
  logic [AW:0] wgray_q, wgray_d;
  logic [AW:0] rq1_q, rq2_q;
  logic [AW:0] rbin;
  logic [AW:0] level_d;
  logic        full_q, full_d;
  logic        af_q, af_d;
  logic [AW:0] level_q;
  logic        ovf_q, ovf_d;
  logic        accept;

  // Gray-to-binary of the synchronised read pointer: each binary bit is the
  // XOR of all Gray bits at and above it.
  for (genvar gi = 0; gi <= AW; gi++) begin : g_rbin
    assign rbin[gi] = ^(rq2_q >> gi);
  end

  // Next-state computation for pointers and status, all from registered state.
  always_comb begin
    accept   = wr_en & ~full_q;
    wbin_d   = wbin_q + {{AW{1'b0}}, accept};
    wgray_d  = wbin_d ^ (wbin_d >> 1);
    level_d  = wbin_d - rbin;
    // Full when the next write pointer sits exactly one lap ahead of the
    // synchronised read pointer: top two Gray bits inverted, rest equal.
    full_d   = (wgray_d == {~rq2_q[AW], ~rq2_q[AW-1], rq2_q[AW-2:0]});
    af_d     = (level_d >= AF_TH_W);
    ovf_d    = wr_en & full_q;
  end

  // Pointer, synchroniser and status registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      rq1_q   <= '0;
      rq2_q   <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      rq1_q   <= rptr_gray;
      rq2_q   <= rq1_q;
      full_q  <= full_d;
      af_q    <= af_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  assign waddr       = wbin_q[AW-1:0];
  assign wram_we     = accept;
  assign wptr_gray   = wgray_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign wlevel      = level_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// Self-checking bench for fifo_wptr_ctrl: a behavioural occupancy model is
// compared against the DUT every cycle, with directed scenarios pinning it.
module tb_fifo_wptr_ctrl;
  localparam int AW    = 4;
  localparam int AF_TH = 12;
  localparam int DEPTH = 1 << AW;
  localparam int PMOD  = 2 * DEPTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW:0]   rptr_gray = '0;
  logic [AW-1:0] waddr;
  logic          wram_we;
  logic [AW:0]   wptr_gray;
  logic          full;
  logic          almost_full;
  logic [AW:0]   wlevel;
  logic          overflow;

  fifo_wptr_ctrl #(.AW(AW), .AF_TH(AF_TH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rptr_gray(rptr_gray),
    .waddr(waddr), .wram_we(wram_we), .wptr_gray(wptr_gray), .full(full),
    .almost_full(almost_full), .wlevel(wlevel), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int b2g(input int b);
    return (b ^ (b >> 1)) % PMOD;
  endfunction

  function automatic int g2b(input int g);
    int b = 0;
    for (int i = AW; i >= 0; i--) b |= (((b >> (i + 1)) & 1) ^ ((g >> i) & 1)) << i;
    return b;
  endfunction

  // Behavioural model: write count, read-pointer delay line, occupancy.
  int m_wbin = 0, m_rq1 = 0, m_rq2 = 0, m_lvl = 0;
  bit m_full = 0, m_af = 0, m_ovf = 0, started = 0;

  always @(posedge clk) begin
    int acc, nb;
    if (rst) begin
      m_wbin = 0; m_rq1 = 0; m_rq2 = 0; m_lvl = 0;
      m_full = 0; m_af = 0; m_ovf = 0;
    end else begin
      acc    = (wr_en && !m_full) ? 1 : 0;
      m_ovf  = wr_en && m_full;
      nb     = (m_wbin + acc) % PMOD;
      m_lvl  = (nb - g2b(m_rq2) + PMOD) % PMOD;
      m_full = (m_lvl == DEPTH);
      m_af   = (m_lvl >= AF_TH);
      m_wbin = nb;
      m_rq2  = m_rq1;
      m_rq1  = int'(rptr_gray);
    end
    started = 1;
  end

  // Per-cycle comparison against the model, mid-cycle when everything is stable.
  always @(negedge clk) begin
    if (started) begin
      chk("waddr", int'(waddr), m_wbin % DEPTH);
      chk("wram_we", int'(wram_we), (wr_en && !m_full) ? 1 : 0);
      chk("wptr_gray", int'(wptr_gray), b2g(m_wbin));
      chk("full", int'(full), int'(m_full));
      chk("almost_full", int'(almost_full), int'(m_af));
      chk("wlevel", int'(wlevel), m_lvl);
      chk("overflow", int'(overflow), int'(m_ovf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int gseq [5] = '{1, 3, 2, 6, 7};
  int q [$];
  int prev_g, cur_g, rd_bin;
  bit wrapped;

  initial begin
    // 1. reset and idle
    rst = 1; wr_en = 0; rptr_gray = 0;
    repeat (3) tick();
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_gray", int'(wptr_gray), 0);
      chk("idle_status", int'({full, almost_full, overflow, wram_we}), 0);
      chk("idle_waddr", int'(waddr), 0);
    end

    // 2. fill to full and beyond
    for (int i = 1; i <= 18; i++) begin
      wr_en = 1;
      tick();
      if (i <= 5) chk("fill_gray_seq", int'(wptr_gray), gseq[i-1]);
      if (i == 11) chk("af_before_12", int'(almost_full), 0);
      if (i == 12) chk("af_at_12", int'(almost_full), 1);
      if (i == 15) chk("not_full_15", int'(full), 0);
      if (i == 16) begin
        chk("full_at_16", int'(full), 1);
        chk("level_16", int'(wlevel), 16);
        chk("gray_16", int'(wptr_gray), 5'b11000);
      end
      if (i >= 17) begin
        chk("ovf_pulse", int'(overflow), 1);
        chk("ovf_gray_hold", int'(wptr_gray), 5'b11000);
        chk("ovf_we_blocked", int'(wram_we), 0);
      end
    end

    // 3. release from full
    wr_en = 0; rptr_gray = 5'b00001;
    tick(); chk("rel_edge1_full", int'(full), 1);
    tick(); chk("rel_edge2_full", int'(full), 1);
    tick(); chk("rel_edge3_full", int'(full), 0);
    chk("rel_level", int'(wlevel), 15);
    wr_en = 1; #1;
    chk("rel_waddr", int'(waddr), 0);
    chk("rel_we", int'(wram_we), 1);
    tick(); wr_en = 0;

    // 4. wrap-around with read pointer trailing by 4 cycles
    rst = 1; rptr_gray = 0; tick(); rst = 0;
    q.delete(); wrapped = 0; prev_g = 0;
    for (int i = 0; i < 40; i++) begin
      wr_en = 1;
      tick();
      cur_g = int'(wptr_gray);
      chk("wrap_gray_1bit", $countones(cur_g ^ prev_g), 1);
      if (prev_g == 5'b10000 && cur_g == 0) wrapped = 1;
      prev_g = cur_g;
      q.push_back(b2g(m_wbin));
      if (q.size() > 4) rptr_gray = (AW+1)'(q.pop_front());
    end
    chk("wrap_seen", int'(wrapped), 1);
    wr_en = 0;

    // 5. write coinciding with read-pointer advance at level 15
    rst = 1; rptr_gray = 0; tick(); rst = 0;
    wr_en = 1; repeat (15) tick();
    wr_en = 0; rptr_gray = 5'b00001;
    tick(); tick();
    chk("sim_level_pre", int'(wlevel), 15);
    wr_en = 1; tick(); wr_en = 0;
    chk("sim_full", int'(full), 0);
    chk("sim_level", int'(wlevel), 15);

    // 6. reset in the middle of a burst
    rst = 1; rptr_gray = 0; tick(); rst = 0;
    wr_en = 1; repeat (9) tick();
    chk("mid_level9", int'(wlevel), 9);
    rst = 1; tick(); rst = 0; wr_en = 0;
    chk("mid_rst_regs", int'({full, almost_full, overflow, wlevel, wptr_gray}), 0);
    chk("mid_rst_waddr", int'(waddr), 0);
    wr_en = 1; #1;
    chk("post_rst_waddr", int'(waddr), 0);
    tick(); wr_en = 0;

    // Random traffic with a well-behaved reader and occasional resets.
    rst = 1; rptr_gray = 0; rd_bin = 0; tick(); rst = 0;
    for (int i = 0; i < 600; i++) begin
      wr_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1; rd_bin = 0;
      end else begin
        rst = 0;
        if ($urandom_range(0, 2) == 0 && rd_bin != m_wbin) rd_bin = (rd_bin + 1) % PMOD;
      end
      rptr_gray = (AW+1)'(b2g(rd_bin));
      tick();
    end
    rst = 0; wr_en = 0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/fifo_wptr_ctrl.md
Name: fifo_wptr_ctrl

Overview:
Write-side pointer controller for a dual-clock FIFO, running entirely in the write clock domain.
- Sequences the binary write pointer and produces its Gray-coded copy for export to the read domain.
- Synchronises the incoming Gray read pointer.
- Generates full, almost_full, fill level and overflow status for the FIFO's write port and RAM write address.

Parameters:
AW, 4, RAM address width; FIFO depth = 2**AW; legal range 2..16.
AF_TH, 12, almost_full threshold in entries; legal range 1..2**AW.

Ports:
clk  input  1  write-domain clock, all logic on rising edge
rst  input  1  synchronous active-high reset
wr_en  input  1  write request from producer
rptr_gray  input  AW+1  Gray read pointer from read domain (asynchronous to clk)
waddr  output  AW  RAM write address = wbin[AW-1:0]
wram_we  output  1  RAM write strobe = wr_en & ~full (combinational)
wptr_gray  output  AW+1  registered Gray write pointer for export
full  output  1  FIFO full (registered)
almost_full  output  1  level >= AF_TH (registered)
wlevel  output  AW+1  fill level as seen by write side (registered)
overflow  output  1  one-cycle pulse: write attempted while full

Behaviour:
- Reset (rst=1 at clk edge) clears:
  - wbin, wptr_gray and both rptr sync stages to 0.
  - full=0, almost_full=0, wlevel=0, overflow=0.
  - Reset takes priority over all other activity, including mid-write.
- Accept condition: accept = wr_en & ~full, evaluated on current-cycle registered full. wram_we = accept, same cycle; waddr valid in the same cycle.
- Pointer update:
  - wbin_next = wbin + accept, mod 2**(AW+1), wrapping from all-ones to 0.
  - wgray_next = wbin_next ^ (wbin_next >> 1).
  - wbin <= wbin_next and wptr_gray <= wgray_next every cycle.
  - wptr_gray changes by exactly one bit per accepted write, including at wrap.
- Read pointer synchronisation:
  - Two-flop chain rq1 <= rptr_gray, rq2 <= rq1.
  - rq2 is the only read-pointer value used by the logic.
  - Input change is visible in rq2 two edges later.
- Full (registered):
  - full <= (wgray_next == {~rq2[AW], ~rq2[AW-1], rq2[AW-2:0]}).
  - full asserts on the edge that accepts the DEPTH-th unread entry.
- Level:
  - rbin = Gray-to-binary of rq2: rbin[AW] = rq2[AW], and rbin[i] = rbin[i+1] ^ rq2[i].
  - wlevel <= wbin_next - rbin, mod 2**(AW+1); range 0..DEPTH.
  - almost_full <= (wbin_next - rbin) >= AF_TH.
- Overflow: overflow <= wr_en & full. The write is dropped and wbin is unchanged.
- Release from full: after a read-pointer advance at the input, full deasserts on the 3rd clk edge (2 sync edges + 1 registered compare).
- Simultaneous write and read-pointer advance: both are reflected in the same recompute. full is never asserted while level < DEPTH as computed from rq2.
- Conservatism: full and level are pessimistic (stale read pointer) and never report space that does not exist.
- Timing: no combinational path from rptr_gray to any output.

Test Plan:
1. Reset/idle: hold rst 3 cycles, then release with wr_en=0 and rptr_gray=0 -> all outputs 0; waddr=0; wptr_gray=0 for 10 cycles.
2. Fill to full (AW=4, rptr_gray=0): wr_en=1 for 18 cycles ->
   - wptr_gray steps 00000, 00001, 00011, 00010, 00110...
   - After 16th accept: full=1, wlevel=16, wptr_gray=11000.
   - almost_full=1 after 12th accept.
   - Cycles 17–18: wram_we=0 and overflow=1 on each following cycle; wptr_gray holds.
3. Release: from full, set rptr_gray=00001 -> full=0 exactly 3 edges later and wlevel=15; next wr_en accept writes waddr=0.
4. Wrap-around: stream 40 writes with rptr_gray tracking wptr_gray delayed 4 cycles ->
   - wbin wraps 31->0 with wptr_gray 10000->00000.
   - Single-bit Gray change on every accept.
   - full never asserts.
5. Simultaneous events: at level 15, wr_en=1 in the same cycle rq2 advances by 1 -> full stays 0 and wlevel stays 15.
6. Mid-operation reset: assert rst during a write burst at level 9 -> next edge all outputs 0 and waddr=0; first post-reset write goes to waddr=0.
